// File: rtl/tx_resp_arbiter_if.sv
// Response-source and TX FIFO write-side signals of the TX response arbiter.
// master: the arbiter itself; slave: the sources and FIFO around it.
interface tx_resp_arbiter_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_OUT_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]    Rd_data;
   logic                     Rd_data_valid;
   logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
   logic                     ALU_OUT_valid;
   logic                     Wr_Ack;
   logic                     Full;
   logic [DATA_WIDTH-1:0]    FIFO_IN;
   logic                     Wr_Req;
   logic                     REG_RDY;
   logic                     ALU_RDY;
   logic                     Busy;
   logic                     Ack_Timeout;
   logic                     Overflow;

   modport master (
      input  Rd_data, Rd_data_valid, ALU_OUT, ALU_OUT_valid, Wr_Ack, Full,
      output FIFO_IN, Wr_Req, REG_RDY, ALU_RDY, Busy, Ack_Timeout, Overflow
   );

   modport slave (
      output Rd_data, Rd_data_valid, ALU_OUT, ALU_OUT_valid, Wr_Ack, Full,
      input  FIFO_IN, Wr_Req, REG_RDY, ALU_RDY, Busy, Ack_Timeout, Overflow
   );
endinterface

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter sharing the TX FIFO write port between register read data
// (1 byte) and ALU results (2 bytes, low first), with an ack timeout.
//   state | meaning
//   IDLE  | no transaction; grant a pending buffer if any
//   REQ   | FIFO_IN held, Wr_Req raised whenever the FIFO is not full
module tx_resp_arbiter #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int ACK_TIMEOUT   = 15,
   parameter int TMO_WIDTH     = 4
) (
   input logic                CLK,
   input logic                rst,
   tx_resp_arbiter_if.master  bus
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t                   state_q, state_d;
   logic                     rr_alu_q, rr_alu_d;
   logic                     gnt_alu_q, gnt_alu_d;
   logic                     byte_idx_q, byte_idx_d;
   logic [TMO_WIDTH-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic [DATA_WIDTH-1:0]    fifo_in_q, fifo_in_d;
   logic                     reg_pend_q, reg_pend_d;
   logic                     alu_pend_q, alu_pend_d;
   logic [DATA_WIDTH-1:0]    reg_data_q, reg_data_d;
   logic [ALU_OUT_WIDTH-1:0] alu_data_q, alu_data_d;
   logic                     overflow_q, overflow_d;
   logic                     ack_tmo_q, ack_tmo_d;
   logic                     wr_req;
   logic                     release_buf;

   // Combinational so that an async reset drops the request at once.
   assign wr_req = (state_q == REQ) && !bus.Full;

   always_comb begin
      state_d     = state_q;
      rr_alu_d    = rr_alu_q;
      gnt_alu_d   = gnt_alu_q;
      byte_idx_d  = byte_idx_q;
      tmo_cnt_d   = tmo_cnt_q;
      fifo_in_d   = fifo_in_q;
      reg_pend_d  = reg_pend_q;
      alu_pend_d  = alu_pend_q;
      reg_data_d  = reg_data_q;
      alu_data_d  = alu_data_q;
      overflow_d  = overflow_q;
      ack_tmo_d   = 1'b0;
      release_buf = 1'b0;

      if (bus.Rd_data_valid) begin
         if (!reg_pend_q) begin
            reg_pend_d = 1'b1;
            reg_data_d = bus.Rd_data;
         end else begin
            overflow_d = 1'b1;
         end
      end
      if (bus.ALU_OUT_valid) begin
         if (!alu_pend_q) begin
            alu_pend_d = 1'b1;
            alu_data_d = bus.ALU_OUT;
         end else begin
            overflow_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (reg_pend_q || alu_pend_q) begin
               gnt_alu_d  = alu_pend_q && (!reg_pend_q || rr_alu_q);
               rr_alu_d   = !gnt_alu_d;
               fifo_in_d  = gnt_alu_d ? alu_data_q[DATA_WIDTH-1:0] : reg_data_q;
               byte_idx_d = 1'b0;
               tmo_cnt_d  = '0;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (bus.Wr_Ack) begin
               if (gnt_alu_q && !byte_idx_q) begin
                  fifo_in_d  = alu_data_q[ALU_OUT_WIDTH-1:DATA_WIDTH];
                  byte_idx_d = 1'b1;
                  tmo_cnt_d  = '0;
               end else begin
                  release_buf = 1'b1;
               end
            end else if (wr_req) begin
               if (tmo_cnt_q == TMO_WIDTH'(ACK_TIMEOUT - 1)) begin
                  release_buf = 1'b1;
                  ack_tmo_d   = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A buffer being released was pending, so no capture collides here.
      if (release_buf) begin
         state_d = IDLE;
         if (gnt_alu_q) alu_pend_d = 1'b0;
         else           reg_pend_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_alu_q   <= 1'b0;
         gnt_alu_q  <= 1'b0;
         byte_idx_q <= 1'b0;
         tmo_cnt_q  <= '0;
         fifo_in_q  <= '0;
         reg_pend_q <= 1'b0;
         alu_pend_q <= 1'b0;
         reg_data_q <= '0;
         alu_data_q <= '0;
         overflow_q <= 1'b0;
         ack_tmo_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_alu_q   <= rr_alu_d;
         gnt_alu_q  <= gnt_alu_d;
         byte_idx_q <= byte_idx_d;
         tmo_cnt_q  <= tmo_cnt_d;
         fifo_in_q  <= fifo_in_d;
         reg_pend_q <= reg_pend_d;
         alu_pend_q <= alu_pend_d;
         reg_data_q <= reg_data_d;
         alu_data_q <= alu_data_d;
         overflow_q <= overflow_d;
         ack_tmo_q  <= ack_tmo_d;
      end
   end

   assign bus.FIFO_IN     = fifo_in_q;
   assign bus.Wr_Req      = wr_req;
   assign bus.REG_RDY     = !reg_pend_q;
   assign bus.ALU_RDY     = !alu_pend_q;
   assign bus.Busy        = (state_q != IDLE);
   assign bus.Ack_Timeout = ack_tmo_q;
   assign bus.Overflow    = overflow_q;

endmodule
